// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a registered-read synchronous FIFO and
// serialises each one onto a UART-style line: start bit, data LSB first,
// optional even parity, one stop bit.
//
// FIFO handshake: fifo_re is a one-cycle request issued only after the bench
// of this block has seen fifo_empty low at a clock edge while idle (or on the
// last stop-bit cycle). The FIFO answers one cycle later: fifo_data is valid
// during the cycle after fifo_re and is captured at the end of that cycle.
// fifo_re is never held for two consecutive cycles.
//
// Every output is a flop computed from the next state, so no input reaches
// an output combinationally. state_dbg exposes the FSM state for checkers.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_re,
  output logic              tx,
  output logic              busy,
  output logic              byte_done,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              fifo_re_q, fifo_re_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              byte_done_q, byte_done_d;
  logic              bit_last;
  logic              can_start;

  assign bit_last  = (cnt_q == CNT_LAST);
  assign can_start = en && !fifo_empty;

  // Next-state, counter and shift-register logic; outputs derive from state_d.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_start) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        // fifo_data is the byte requested in POP; capture it now.
        shift_d = fifo_data;
        par_d   = ^fifo_data;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_last) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_last) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          cnt_d       = '0;
          byte_done_d = 1'b1;
          // Back-to-back frames go straight to POP, skipping IDLE.
          state_d     = can_start ? POP : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    fifo_re_d = (state_d == POP);
    busy_d    = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      fifo_re_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      fifo_re_q   <= fifo_re_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign fifo_re   = fifo_re_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (no parity / even parity) at
// CLKS_PER_BIT=4, each fed by a small FIFO model with one-cycle read latency.
// A per-cycle reference model predicts fifo_re, tx, busy and byte_done from
// the frame rules; table vectors, hand sequences and random traffic drive it.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  // Clock and reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT-side signals, index 0 = no parity, index 1 = parity
  logic [1:0]      en;
  logic [1:0]      empty;
  logic [1:0][7:0] fd;
  logic [1:0]      fre;
  logic [1:0]      tx;
  logic [1:0]      busy;
  logic [1:0]      bdone;
  logic [2:0]      st0, st1;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) dut (
    .clk(clk), .rst(rst), .en(en[0]), .fifo_empty(empty[0]), .fifo_data(fd[0]),
    .fifo_re(fre[0]), .tx(tx[0]), .busy(busy[0]), .byte_done(bdone[0]),
    .state_dbg(st0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .en(en[1]), .fifo_empty(empty[1]), .fifo_data(fd[1]),
    .fifo_re(fre[1]), .tx(tx[1]), .busy(busy[1]), .byte_done(bdone[1]),
    .state_dbg(st1)
  );

  // FIFO models: storage/wp written by the stimulus, rp and fd by the read port
  logic [7:0] mem [2][64];
  int wp [2];
  int rp [2];

  assign empty[0] = (wp[0] == rp[0]);
  assign empty[1] = (wp[1] == rp[1]);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fre[i] && (wp[i] != rp[i])) begin
        fd[i] <= mem[i][rp[i] % 64];
        rp[i] <= rp[i] + 1;
      end
    end
  end

  // Scoreboard bookkeeping
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected tx level at position pos, counting from the fifo_re cycle.
  function automatic logic frame_bit(input logic [7:0] b, input int pos, input bit par);
    int k;
    if (pos < 2) return 1'b1;
    k = (pos - 2) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (par && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Reference model state (owned by the monitor)
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int   seen    [2] = '{0, 0};
  int   fpos    [2] = '{-1, -1};
  int   done_at [2] = '{-1, -1};
  logic pend    [2] = '{1'b0, 1'b0};
  logic [7:0] cur [2];
  int   cyc = 0;
  int   re_cnt [2]    = '{0, 0};
  int   done_cnt [2]  = '{0, 0};
  int   busy_cnt [2]  = '{0, 0};
  int   txlow_cnt [2] = '{0, 0};

  // Per-cycle monitor: predict and compare every output away from the edge
  always @(negedge clk) begin
    cyc++;
    while (seen[0] != wp[0]) begin exp_q0.push_back(mem[0][seen[0] % 64]); seen[0]++; end
    while (seen[1] != wp[1]) begin exp_q1.push_back(mem[1][seen[1] % 64]); seen[1]++; end
    for (int i = 0; i < 2; i++) begin : per_inst
      int   flen;
      logic e_tx, e_busy, e_bd, e_fre;
      int   qsz;
      flen = 2 + (10 + i) * CPB;
      if (!rst) begin
        pend[i]    = 1'b0;
        fpos[i]    = -1;
        done_at[i] = -1;
        e_fre = 1'b0; e_tx = 1'b1; e_busy = 1'b0; e_bd = 1'b0;
      end else begin
        e_fre = pend[i];
        if (e_fre) begin
          qsz = (i == 0) ? exp_q0.size() : exp_q1.size();
          check($sformatf("model_pop%0d@%0d", i, cyc), (qsz > 0), 1'b1);
          if (qsz > 0) cur[i] = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          fpos[i] = 0;
        end
        e_bd = (cyc == done_at[i]);
        if (fpos[i] >= 0) begin
          e_busy = 1'b1;
          e_tx   = frame_bit(cur[i], fpos[i], (i == 1));
        end else begin
          e_busy = 1'b0;
          e_tx   = 1'b1;
        end
        pend[i] = en[i] && !empty[i] && ((fpos[i] < 0) || (fpos[i] == flen - 1));
        if (fpos[i] >= 0) begin
          fpos[i]++;
          if (fpos[i] == flen) begin
            fpos[i]    = -1;
            done_at[i] = cyc + 1;
          end
        end
      end
      check($sformatf("fifo_re%0d@%0d", i, cyc), fre[i], e_fre);
      check($sformatf("tx%0d@%0d", i, cyc), tx[i], e_tx);
      check($sformatf("busy%0d@%0d", i, cyc), busy[i], e_busy);
      check($sformatf("byte_done%0d@%0d", i, cyc), bdone[i], e_bd);
      re_cnt[i]    += int'(fre[i]);
      done_cnt[i]  += int'(bdone[i]);
      busy_cnt[i]  += int'(busy[i]);
      txlow_cnt[i] += int'(!tx[i]);
    end
  end

  // Driver tasks
  task automatic push(input int i, input logic [7:0] b);
    mem[i][wp[i] % 64] = b;
    wp[i] = wp[i] + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int i);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (n < 3000 && !ok) begin
      tick(1);
      n++;
      if (wp[i] == rp[i] && !busy[i]) ok = 1'b1;
    end
    check($sformatf("drain_timeout%0d", i), ok, 1'b1);
    tick(3);
  endtask

  task automatic wait_fre0(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (fre[0]) ok = 1'b1;
    end
    check("wait_fifo_re", ok, 1'b1);
  endtask

  // Table-driven vectors
  typedef struct {
    int         inst;
    int         nb;
    logic [7:0] d [3];
    int         exp_re;
    int         exp_done;
    int         exp_busy;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int   b_re, b_done, b_busy, b_low;
    int   pushed [2];
    bit   ok;

    vecs[0] = '{inst: 0, nb: 1, d: '{8'hA5, 8'h00, 8'h00}, exp_re: 1, exp_done: 1, exp_busy: 42};
    vecs[1] = '{inst: 0, nb: 3, d: '{8'h01, 8'h80, 8'hFF}, exp_re: 3, exp_done: 3, exp_busy: 126};
    vecs[2] = '{inst: 1, nb: 1, d: '{8'h07, 8'h00, 8'h00}, exp_re: 1, exp_done: 1, exp_busy: 46};
    vecs[3] = '{inst: 1, nb: 1, d: '{8'h03, 8'h00, 8'h00}, exp_re: 1, exp_done: 1, exp_busy: 46};
    vecs[4] = '{inst: 1, nb: 2, d: '{8'h3C, 8'hC3, 8'h00}, exp_re: 2, exp_done: 2, exp_busy: 92};

    rst = 1'b0;
    en  = 2'b00;
    tick(3);
    check("reset_tx", tx, 2'b11);
    check("reset_busy", busy, 2'b00);
    check("reset_fifo_re", fre, 2'b00);
    check("reset_byte_done", bdone, 2'b00);
    rst = 1'b1;
    tick(2);

    // Empty FIFO with en high: nothing happens, then a single write.
    b_re = re_cnt[0]; b_busy = busy_cnt[0]; b_low = txlow_cnt[0]; b_done = done_cnt[0];
    en[0] = 1'b1;
    tick(50);
    check("empty_no_re", re_cnt[0] - b_re, 0);
    check("empty_no_busy", busy_cnt[0] - b_busy, 0);
    check("empty_tx_high", txlow_cnt[0] - b_low, 0);
    push(0, 8'h5A);
    wait_drain(0);
    check("single_write_done", done_cnt[0] - b_done, 1);
    en[0] = 1'b0;
    tick(2);

    // Table vectors
    for (int v = 0; v < 5; v++) begin
      int i;
      i = vecs[v].inst;
      b_re = re_cnt[i]; b_done = done_cnt[i]; b_busy = busy_cnt[i];
      for (int k = 0; k < vecs[v].nb; k++) push(i, vecs[v].d[k]);
      en[i] = 1'b1;
      wait_drain(i);
      en[i] = 1'b0;
      tick(2);
      check($sformatf("vec%0d_re", v), re_cnt[i] - b_re, vecs[v].exp_re);
      check($sformatf("vec%0d_done", v), done_cnt[i] - b_done, vecs[v].exp_done);
      check($sformatf("vec%0d_busy", v), busy_cnt[i] - b_busy, vecs[v].exp_busy);
      check($sformatf("vec%0d_empty", v), empty[i], 1'b1);
    end

    // Enable gating: hold off, then send, then drop en during byte 1 DATA.
    b_re = re_cnt[0]; b_done = done_cnt[0]; b_low = txlow_cnt[0];
    push(0, 8'h96);
    push(0, 8'h69);
    tick(100);
    check("gate_no_re", re_cnt[0] - b_re, 0);
    check("gate_tx_high", txlow_cnt[0] - b_low, 0);
    en[0] = 1'b1;
    wait_fre0(ok);
    tick(10);
    en[0] = 1'b0;
    tick(150);
    check("gate_one_done", done_cnt[0] - b_done, 1);
    check("gate_one_re", re_cnt[0] - b_re, 1);
    check("gate_byte2_kept", empty[0], 1'b0);
    en[0] = 1'b1;
    wait_drain(0);
    check("gate_both_done", done_cnt[0] - b_done, 2);
    en[0] = 1'b0;
    tick(2);

    // Reset during DATA bit 3 aborts the frame without a clock edge.
    b_re = re_cnt[0]; b_done = done_cnt[0];
    push(0, 8'hF0);
    push(0, 8'h0F);
    en[0] = 1'b1;
    wait_fre0(ok);
    tick(19);
    rst = 1'b0;
    #1;
    check("rst_async_tx", tx[0], 1'b1);
    check("rst_async_busy", busy[0], 1'b0);
    check("rst_async_re", fre[0], 1'b0);
    tick(3);
    check("rst_hold_re", re_cnt[0] - b_re, 1);
    rst = 1'b1;
    wait_drain(0);
    check("rst_fresh_pop", re_cnt[0] - b_re, 2);
    check("rst_one_done", done_cnt[0] - b_done, 1);
    en[0] = 1'b0;
    tick(2);

    // Random traffic on both instances with random enable toggling.
    pushed[0] = 0; pushed[1] = 0;
    b_done = done_cnt[0];
    b_busy = done_cnt[1];
    en = 2'b11;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 39) == 0 && (wp[i] - rp[i]) < 12) begin
          push(i, 8'($urandom));
          pushed[i]++;
        end
        if ($urandom_range(0, 29) == 0) en[i] = ~en[i];
      end
      tick(1);
    end
    en = 2'b11;
    wait_drain(0);
    wait_drain(1);
    check("rand_done0", done_cnt[0] - b_done, pushed[0]);
    check("rand_done1", done_cnt[1] - b_busy, pushed[1]);
    check("rand_model_empty0", exp_q0.size(), 0);
    check("rand_model_empty1", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the team's 16x8 synchronous FIFO.
- Pops one byte at a time through the FIFO's registered read port (re / empty / data_out, one-cycle read latency).
- Serialises each byte onto a single UART-style line: start bit, data LSB first, optional even parity, one stop bit.
- Sits between the FIFO and the chip-level tx pin.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
- DATA_W, 8, bits per frame; matches FIFO width.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.

Ports:
- clk  input  1  rising-edge clock shared with the FIFO.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  level enable; new frames start only while high.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO data_out.
- fifo_re  output  1  FIFO read enable; registered.
- tx  output  1  serial line; idles high.
- busy  output  1  high from pop through end of stop bit.
- byte_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - Output values: tx=1, fifo_re=0, busy=0, byte_done=0.
  - Internal state: state=IDLE, all counters 0, shift register 0.
  - Reset mid-frame aborts the frame immediately. The popped byte is lost. No further fifo_re until rst=1 and a clk edge.
- All outputs are registered; no combinational paths from inputs to outputs.
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0. If en=1 and fifo_empty=0, next state is POP.
- POP: exactly one cycle with fifo_re=1, busy=1, tx=1. Next state is LOAD.
- LOAD: fifo_re=0, tx=1. fifo_data is valid this cycle and is captured into the shift register at the closing edge. Parity = XOR of the data bits. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right, DATA_W bits.
- Bit-index counter width is $clog2(DATA_W). Bit-time counter width is $clog2(CLKS_PER_BIT) and counts 0..CLKS_PER_BIT-1.
- PARITY: present only if PARITY_EN=1. tx=parity (even) for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - On the final cycle, byte_done is registered high for exactly the next cycle.
  - If en=1 and fifo_empty=0, next state is POP (back-to-back); otherwise IDLE.
- Frame timing:
  - Frame length on tx is (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles.
  - First tx=0 cycle is 2 cycles after the fifo_re cycle.
  - Back-to-back frames have exactly 2 extra idle-high cycles (POP, LOAD) between stop bit and next start bit.
- en deasserted mid-frame: the current frame completes unchanged; no new pop.
- en and fifo_empty are sampled only in IDLE and on the last STOP cycle. Changes at other times are ignored.
- fifo_empty going high during a frame has no effect; this block is the sole FIFO reader.
- fifo_re is never asserted while fifo_empty=1 at the sampling edge. fifo_re is never high on two consecutive cycles.

Test Plan:
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0:
  - Stimulus: preload 0xA5, en=1.
  - fifo_re high exactly 1 cycle.
  - 2 cycles later, tx = 0x4, then 1,0,1,0,0,1,0,1 (each x4), then 1x4.
  - byte_done pulses once; busy high 42 cycles; FIFO empty afterwards.
- Back-to-back, CLKS_PER_BIT=4:
  - Stimulus: preload 0x01, 0x80, 0xFF.
  - Exactly 3 fifo_re pulses, 42 cycles apart.
  - Decoded bytes are 0x01, 0x80, 0xFF in order; 2 idle-high cycles between frames; 3 byte_done pulses.
- Parity, PARITY_EN=1, CLKS_PER_BIT=4:
  - 0x07: parity bit 1, frame length 44 cycles.
  - 0x03: parity bit 0.
- Enable gating:
  - en=0 with FIFO holding 2 bytes: no fifo_re, tx stays 1 for 100 cycles.
  - Raise en: both bytes sent.
  - Drop en during byte 1's DATA state: byte 1 completes, byte 2 is not popped.
- Reset mid-frame:
  - Assert rst=0 during DATA bit 3: tx=1 and busy=0 with no clk edge required.
  - Release rst with 1 byte queued: a clean full frame of that byte follows, starting with a fresh POP.
- Empty FIFO:
  - en=1, fifo_empty=1 for 50 cycles: fifo_re never asserted, busy=0, tx=1.
  - Single write: frame starts; fifo_re asserts only after empty is observed low.
